// File: rtl/spi_register_bank.sv
`default_nettype none
// spi_register_bank: decodes received SPI words into control fields and streams status words out.
// Optional macro SPI_REG_READBACK_EN adds the READBACK command (field echo on the transmit path).
module spi_register_bank #(
  parameter int DATA_W     = 12,
  parameter int CMD_W      = 4,
  parameter int NUM_FIELDS = 6,
  parameter int NUM_STAT   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CMD_W+DATA_W-1:0]      spi_data,
  input  logic                         rx_busy,
  input  logic                         tx_busy,
  input  logic [NUM_STAT*DATA_W-1:0]   status_in,
  output logic [NUM_FIELDS*DATA_W-1:0] field_out,
  output logic [NUM_FIELDS-1:0]        wr_strobe,
  output logic [CMD_W+DATA_W-1:0]      tx_word,
  output logic [7:0]                   err_count
);

  localparam int WORD_W = CMD_W + DATA_W;
  localparam int SIDX_W = (NUM_STAT > 1) ? $clog2(NUM_STAT) : 1;
  localparam logic [CMD_W-1:0]  CMD_NOP        = '0;
  localparam logic [CMD_W-1:0]  CMD_LAST_FIELD = CMD_W'(NUM_FIELDS);
  localparam logic [SIDX_W-1:0] STAT_LAST      = SIDX_W'(NUM_STAT - 1);

  logic [1:0]            rx_sync, tx_sync;
  logic                  rx_prev, tx_prev;
  logic                  rx_fall, tx_fall;
  logic [WORD_W-1:0]     rx_word;
  logic                  rx_valid;
  logic [DATA_W-1:0]     fields  [NUM_FIELDS];
  logic [DATA_W-1:0]     stat_ch [NUM_STAT];
  logic [SIDX_W-1:0]     stat_idx;
  logic [CMD_W-1:0]      cmd;
  logic [DATA_W-1:0]     payload;
  logic [NUM_FIELDS-1:0] wr_onehot;
  logic                  is_write, rb_set, is_err, stat_shipped;
  logic [WORD_W-1:0]     tx_next;

  // Edges are taken between the synchronised value and its one-cycle-delayed copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync <= '0;
      tx_sync <= '0;
      rx_prev <= 1'b0;
      tx_prev <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx_busy};
      tx_sync <= {tx_sync[0], tx_busy};
      rx_prev <= rx_sync[1];
      tx_prev <= tx_sync[1];
    end
  end

  assign rx_fall = rx_prev & ~rx_sync[1];
  assign tx_fall = tx_prev & ~tx_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_word  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= rx_fall;
      if (rx_fall) rx_word <= spi_data;
    end
  end

  assign cmd     = rx_word[WORD_W-1 -: CMD_W];
  assign payload = rx_word[DATA_W-1:0];

  always_comb begin
    wr_onehot = '0;
    is_write  = rx_valid && (cmd != CMD_NOP) && (cmd <= CMD_LAST_FIELD);
    for (int f = 0; f < NUM_FIELDS; f++)
      wr_onehot[f] = is_write && (cmd == CMD_W'(f + 1));
  end

  assign is_err = rx_valid && (cmd != CMD_NOP) && !is_write && !rb_set;

  generate
    for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field_pack
      assign field_out[f*DATA_W +: DATA_W] = fields[f];
    end
    for (genvar k = 0; k < NUM_STAT; k++) begin : g_stat_unpack
      assign stat_ch[k] = status_in[k*DATA_W +: DATA_W];
    end
  endgenerate

`ifdef SPI_REG_READBACK_EN
  localparam int SEL_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_FIELDS - 1);
  localparam logic [CMD_W-1:0] CMD_RB   = '1;

  logic             rb_pending;
  logic [SEL_W-1:0] rb_sel;
  logic             tx_is_rb;

  assign rb_set = rx_valid && (cmd == CMD_RB) && (payload[SEL_W-1:0] <= SEL_LAST);

  // A new READBACK decoded alongside the shipping edge of the previous one keeps pending set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_pending <= 1'b0;
      rb_sel     <= '0;
      tx_is_rb   <= 1'b0;
    end else begin
      if (rb_set) begin
        rb_pending <= 1'b1;
        rb_sel     <= payload[SEL_W-1:0];
      end else if (tx_fall && tx_is_rb) begin
        rb_pending <= 1'b0;
      end
      if (!tx_sync[1]) tx_is_rb <= rb_pending;
    end
  end

  always_comb begin
    tx_next = {CMD_W'(stat_idx), stat_ch[stat_idx]};
    if (rb_pending) tx_next = {CMD_RB, fields[rb_sel]};
  end

  assign stat_shipped = tx_fall & ~tx_is_rb;
`else
  assign rb_set       = 1'b0;
  assign tx_next      = {CMD_W'(stat_idx), stat_ch[stat_idx]};
  assign stat_shipped = tx_fall;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int f = 0; f < NUM_FIELDS; f++) fields[f] <= '0;
      wr_strobe <= '0;
      err_count <= '0;
    end else begin
      wr_strobe <= wr_onehot;
      for (int f = 0; f < NUM_FIELDS; f++)
        if (wr_onehot[f]) fields[f] <= payload;
      if (is_err && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_idx <= '0;
      tx_word  <= '0;
    end else begin
      if (stat_shipped) stat_idx <= (stat_idx == STAT_LAST) ? '0 : stat_idx + SIDX_W'(1);
      if (!tx_sync[1]) tx_word <= tx_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_register_bank.sv
`timescale 1ns/1ps
// tb_spi_register_bank: randomized self-checking bench against a transaction-level model.
module tb_spi_register_bank;
  localparam int DATA_W = 12;
  localparam int CMD_W  = 4;
  localparam int NF     = 6;
  localparam int NS     = 4;
  localparam int WW     = CMD_W + DATA_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 rx_busy = 1'b0;
  logic                 tx_busy = 1'b0;
  logic [WW-1:0]        spi_data = '0;
  logic [NS*DATA_W-1:0] status_in = '0;
  logic [NF*DATA_W-1:0] field_out;
  logic [NF-1:0]        wr_strobe;
  logic [WW-1:0]        tx_word;
  logic [7:0]           err_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DATA_W-1:0] m_field [NF];
  int                m_err;
  int                m_idx;
  bit                m_rb_pend;
  int                m_rb_sel;

  spi_register_bank #(.DATA_W(DATA_W), .CMD_W(CMD_W), .NUM_FIELDS(NF), .NUM_STAT(NS)) dut (
    .clk(clk), .rst(rst), .spi_data(spi_data), .rx_busy(rx_busy), .tx_busy(tx_busy),
    .status_in(status_in), .field_out(field_out), .wr_strobe(wr_strobe),
    .tx_word(tx_word), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int f = 0; f < NF; f++) m_field[f] = '0;
    m_err = 0; m_idx = 0; m_rb_pend = 0; m_rb_sel = 0;
  endfunction

  function automatic logic [NF*DATA_W-1:0] exp_fields();
    logic [NF*DATA_W-1:0] v;
    for (int f = 0; f < NF; f++) v[f*DATA_W +: DATA_W] = m_field[f];
    return v;
  endfunction

  function automatic logic [WW-1:0] exp_tx();
    logic [3:0] tag;
    if (m_rb_pend) return {4'hF, m_field[m_rb_sel]};
    tag = 4'(m_idx);
    return {tag, status_in[m_idx*DATA_W +: DATA_W]};
  endfunction

  function automatic logic [NF-1:0] model_rx(input int cmd, input int pl);
    logic [NF-1:0] s = '0;
    if (cmd == 0) begin
    end else if (cmd <= NF) begin
      m_field[cmd-1] = DATA_W'(pl);
      s[cmd-1] = 1'b1;
    end
`ifdef SPI_REG_READBACK_EN
    else if (cmd == 15 && (pl % 8) < NF) begin
      m_rb_pend = 1; m_rb_sel = pl % 8;
    end
`endif
    else if (m_err < 255) m_err++;
    return s;
  endfunction

  // Drive one rx word; report OR of strobes seen and number of cycles strobe was non-zero.
  task automatic send_rx(input int cmd, input int pl, input int high, input int low,
                         output logic [NF-1:0] seen, output int hits);
    seen = '0; hits = 0;
    @(negedge clk);
    spi_data = {4'(cmd), 12'(pl)};
    rx_busy  = 1'b1;
    repeat (high) @(negedge clk);
    rx_busy = 1'b0;
    for (int k = 0; k < low; k++) begin
      @(negedge clk);
      seen |= wr_strobe;
      if (wr_strobe != '0) hits++;
    end
  endtask

  task automatic pulse_tx();
    @(negedge clk);
    tx_busy = 1'b1;
    repeat (4) @(negedge clk);
    tx_busy = 1'b0;
    if (m_rb_pend) m_rb_pend = 0;
    else m_idx = (m_idx + 1) % NS;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    model_reset();
    status_in = {12'h444, 12'h333, 12'h222, 12'h111};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (field_out !== '0) begin errors++; $display("FAIL reset_fields got=%h exp=0", field_out); end
    checks++; if (wr_strobe !== '0) begin errors++; $display("FAIL reset_strobe got=%h exp=0", wr_strobe); end
    checks++; if (tx_word !== '0) begin errors++; $display("FAIL reset_tx got=%h exp=0", tx_word); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err got=%0d exp=0", err_count); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (wr_strobe !== '0) begin errors++; $display("FAIL post_reset_strobe got=%h exp=0", wr_strobe); end
    checks++; if (tx_word !== exp_tx()) begin errors++; $display("FAIL post_reset_tx got=%h exp=%h", tx_word, exp_tx()); end
  endtask

  task automatic test_write_latency();
    logic [NF-1:0] s;
    s = model_rx(1, 12'hABC);
    @(negedge clk);
    spi_data = {4'h1, 12'hABC};
    rx_busy = 1'b1;
    repeat (4) @(negedge clk);
    rx_busy = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (wr_strobe !== ((k == 4) ? s : '0)) begin
        errors++; $display("FAIL write_strobe_edge%0d got=%h exp=%h", k, wr_strobe, (k == 4) ? s : '0);
      end
      if (k == 3) begin
        checks++; if (field_out !== '0) begin errors++; $display("FAIL write_early got=%h exp=0", field_out); end
      end
    end
    checks++; if (field_out !== exp_fields()) begin errors++; $display("FAIL write_fields got=%h exp=%h", field_out, exp_fields()); end
  endtask

  task automatic test_status_stream();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (tx_word !== exp_tx()) begin errors++; $display("FAIL stream_%0d got=%h exp=%h", i, tx_word, exp_tx()); end
      pulse_tx();
    end
  endtask

  task automatic test_random_words();
    logic [NF-1:0] s, seen;
    int hits, cmd, pl;
    for (int i = 0; i < 40; i++) begin
      cmd = int'($urandom_range(0, 15));
      pl  = int'($urandom_range(0, 4095));
      s = model_rx(cmd, pl);
      send_rx(cmd, pl, 4, 6, seen, hits);
      checks++;
      if (seen !== s || hits != ((s != '0) ? 1 : 0)) begin
        errors++; $display("FAIL rand_strobe_%0d cmd=%0d got=%h/%0d exp=%h", i, cmd, seen, hits, s);
      end
      checks++; if (field_out !== exp_fields()) begin errors++; $display("FAIL rand_fields_%0d got=%h exp=%h", i, field_out, exp_fields()); end
      checks++; if (err_count !== 8'(m_err)) begin errors++; $display("FAIL rand_err_%0d got=%0d exp=%0d", i, err_count, m_err); end
      checks++; if (tx_word !== exp_tx()) begin errors++; $display("FAIL rand_tx_%0d got=%h exp=%h", i, tx_word, exp_tx()); end
    end
    if (m_rb_pend) pulse_tx();
  endtask

  task automatic test_back_to_back();
    logic [NF-1:0] s, seen;
    int hits, cmd, pl;
    for (int i = 0; i < 8; i++) begin
      cmd = int'($urandom_range(1, NF));
      pl  = int'($urandom_range(0, 4095));
      s = model_rx(cmd, pl);
      send_rx(cmd, pl, 4, 4, seen, hits);
      checks++;
      if (seen !== s || hits != 1) begin errors++; $display("FAIL b2b_strobe_%0d got=%h/%0d exp=%h", i, seen, hits, s); end
    end
    repeat (3) @(negedge clk);
    checks++; if (field_out !== exp_fields()) begin errors++; $display("FAIL b2b_fields got=%h exp=%h", field_out, exp_fields()); end
  endtask

  task automatic test_err_saturate();
    logic [NF-1:0] s, seen;
    int hits, any_hits;
    any_hits = 0;
    for (int i = 0; i < 300; i++) begin
      s = model_rx(9, int'($urandom_range(0, 4095)));
      send_rx(9, int'($urandom_range(0, 4095)), 4, 4, seen, hits);
      any_hits += hits;
    end
    repeat (3) @(negedge clk);
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_sat got=%0d exp=255", err_count); end
    checks++; if (any_hits != 0) begin errors++; $display("FAIL err_strobe got=%0d exp=0", any_hits); end
    checks++; if (field_out !== exp_fields()) begin errors++; $display("FAIL err_fields got=%h exp=%h", field_out, exp_fields()); end
  endtask

  task automatic test_tx_hold();
    logic [WW-1:0] held;
    @(negedge clk);
    tx_busy = 1'b1;
    held = exp_tx();
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      status_in = {$urandom, $urandom};
      @(negedge clk);
      checks++; if (tx_word !== held) begin errors++; $display("FAIL tx_hold_%0d got=%h exp=%h", i, tx_word, held); end
    end
    tx_busy = 1'b0;
    m_idx = (m_idx + 1) % NS;
    repeat (5) @(negedge clk);
    checks++; if (tx_word !== exp_tx()) begin errors++; $display("FAIL tx_resume got=%h exp=%h", tx_word, exp_tx()); end
  endtask

  task automatic test_readback();
    logic [NF-1:0] s, seen;
    int hits, idx_before;
    s = model_rx(3, 12'h5A5);
    send_rx(3, 12'h5A5, 4, 6, seen, hits);
    s = model_rx(15, 2);
    send_rx(15, 2, 4, 6, seen, hits);
`ifdef SPI_REG_READBACK_EN
    checks++; if (tx_word !== {4'hF, 12'h5A5}) begin errors++; $display("FAIL rb_word got=%h exp=f5a5", tx_word); end
`endif
    checks++; if (tx_word !== exp_tx()) begin errors++; $display("FAIL rb_tx got=%h exp=%h", tx_word, exp_tx()); end
    checks++; if (err_count !== 8'(m_err)) begin errors++; $display("FAIL rb_err got=%0d exp=%0d", err_count, m_err); end
    idx_before = m_idx;
    pulse_tx();
    checks++; if (tx_word !== exp_tx()) begin errors++; $display("FAIL rb_after got=%h exp=%h idx_before=%0d", tx_word, exp_tx(), idx_before); end
    s = model_rx(15, 7);
    send_rx(15, 7, 4, 6, seen, hits);
    checks++; if (err_count !== 8'(m_err)) begin errors++; $display("FAIL rb_bad_sel got=%0d exp=%0d", err_count, m_err); end
  endtask

  task automatic test_reset_midword();
    int hits;
    @(negedge clk);
    spi_data = {4'h2, 12'h777};
    rx_busy = 1'b1;
    repeat (4) @(negedge clk);
    rx_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    checks++; if (field_out !== '0) begin errors++; $display("FAIL mid_rst_fields got=%h exp=0", field_out); end
    checks++; if (tx_word !== '0 || err_count !== 8'd0 || wr_strobe !== '0) begin
      errors++; $display("FAIL mid_rst_outs got=%h/%0d/%h exp=0", tx_word, err_count, wr_strobe);
    end
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (wr_strobe !== '0) hits++;
    end
    checks++; if (hits != 0) begin errors++; $display("FAIL mid_rst_strobe got=%0d exp=0", hits); end
    checks++; if (field_out !== '0) begin errors++; $display("FAIL mid_rst_after got=%h exp=0", field_out); end
  endtask

  initial begin
    test_reset();
    test_write_latency();
    test_status_stream();
    test_random_words();
    test_back_to_back();
    test_tx_hold();
    test_readback();
    test_err_saturate();
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
